// File: rtl/rep_addr_gen_if.sv
// rtl/rep_addr_gen_if.sv - instruction, activate and address bundle of one rep_addr_gen port
interface rep_addr_gen_if #(
    parameter int ADDR_W = 16
);
    logic              instr_valid;
    logic              instr_ready;
    logic [2:0]        instr_opcode;
    logic [27:0]       instr_payload;
    logic              activate;
    logic [ADDR_W-1:0] base_addr;
    logic              addr_valid;
    logic [ADDR_W-1:0] addr;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  instr_valid,
        output instr_ready,
        input  instr_opcode,
        input  instr_payload,
        input  activate,
        input  base_addr,
        output addr_valid,
        output addr,
        output busy,
        output done,
        output err
    );

    modport master (
        output instr_valid,
        input  instr_ready,
        output instr_opcode,
        output instr_payload,
        output activate,
        output base_addr,
        input  addr_valid,
        input  addr,
        input  busy,
        input  done,
        input  err
    );
endinterface

// File: rtl/rep_addr_gen.sv
// rtl/rep_addr_gen.sv - nested-loop affine address generator fed by rep/repx words
// Optional 12-bit fields with repx high halves: define REP_ADDR_GEN_REPX_EN.
module rep_addr_gen #(
    parameter int SLOT_ID    = 0,
    parameter int PORT_ID    = 0,
    parameter int NUM_LEVELS = 4,
    parameter int ADDR_W     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    rep_addr_gen_if.slave bus
);

`ifdef REP_ADDR_GEN_REPX_EN
    localparam int FW      = 12;
    localparam bit REPX_EN = 1'b1;
`else
    localparam int FW      = 6;
    localparam bit REPX_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [FW-1:0]     iter_q  [NUM_LEVELS];
    logic [FW-1:0]     step_q  [NUM_LEVELS];
    logic [FW-1:0]     delay_q [NUM_LEVELS];
    logic [FW-1:0]     cnt_q   [NUM_LEVELS];
    logic [ADDR_W-1:0] lb_q    [NUM_LEVELS];
    logic [FW-1:0]     wcnt_q;
    logic              err_q;

    logic [3:0] f_slot;
    logic [1:0] f_port;
    logic [3:0] f_lvl;
    logic [5:0] f_iter;
    logic [5:0] f_step;
    logic [5:0] f_delay;

    assign f_slot  = bus.instr_payload[27:24];
    assign f_port  = bus.instr_payload[23:22];
    assign f_lvl   = bus.instr_payload[21:18];
    assign f_iter  = bus.instr_payload[17:12];
    assign f_step  = bus.instr_payload[11:6];
    assign f_delay = bus.instr_payload[5:0];

    logic xfer, own, is_rep, is_repx, lvl_ok, cfg_err, cfg_wr;

    assign xfer    = bus.instr_valid && bus.instr_ready;
    assign own     = (f_slot == 4'(SLOT_ID)) && (f_port == 2'(PORT_ID));
    assign is_rep  = (bus.instr_opcode == 3'd0);
    assign is_repx = (bus.instr_opcode == 3'd1);
    assign lvl_ok  = ({1'b0, f_lvl} < 5'(NUM_LEVELS));
    assign cfg_err = xfer && own &&
                     (((is_rep || is_repx) && !lvl_ok) || (is_repx && !REPX_EN));
    // A word arriving with activate must not alter the run being launched;
    // the run clears config on completion, so the word has no lasting effect.
    assign cfg_wr  = xfer && own && lvl_ok && !bus.activate &&
                     (is_rep || (is_repx && REPX_EN));

    // The only level that can advance is the lowest one not yet at its limit.
    logic                  found;
    logic [NUM_LEVELS-1:0] hit;
    logic [NUM_LEVELS-1:0] below;
    logic [ADDR_W-1:0]     nxt_lb;
    logic [FW-1:0]         sel_delay;

    always_comb begin
        found     = 1'b0;
        hit       = '0;
        below     = '0;
        nxt_lb    = '0;
        sel_delay = '0;
        for (int l = 0; l < NUM_LEVELS; l++) begin
            if (!found) begin
                if (cnt_q[l] < iter_q[l]) begin
                    found     = 1'b1;
                    hit[l]    = 1'b1;
                    nxt_lb    = lb_q[l] + ADDR_W'($signed(step_q[l]));
                    sel_delay = delay_q[l];
                end else begin
                    below[l] = 1'b1;
                end
            end
        end
    end

    logic start, advance, finish;

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        advance = 1'b0;
        finish  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.activate) begin
                    start   = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (found) begin
                    advance = 1'b1;
                    if (sel_delay != '0) begin
                        state_d = S_WAIT;
                    end
                end else begin
                    finish  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (wcnt_q <= FW'(1)) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < NUM_LEVELS; l++) begin
                iter_q[l]  <= '0;
                step_q[l]  <= '0;
                delay_q[l] <= '0;
                cnt_q[l]   <= '0;
                lb_q[l]    <= '0;
            end
            wcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= cfg_err;

            if (start) begin
                for (int l = 0; l < NUM_LEVELS; l++) begin
                    cnt_q[l] <= '0;
                    lb_q[l]  <= bus.base_addr;
                end
            end else if (advance) begin
                for (int l = 0; l < NUM_LEVELS; l++) begin
                    if (hit[l]) begin
                        cnt_q[l] <= cnt_q[l] + FW'(1);
                        lb_q[l]  <= nxt_lb;
                    end else if (below[l]) begin
                        cnt_q[l] <= '0;
                        lb_q[l]  <= nxt_lb;
                    end
                end
            end else if (finish) begin
                for (int l = 0; l < NUM_LEVELS; l++) begin
                    iter_q[l]  <= '0;
                    step_q[l]  <= '0;
                    delay_q[l] <= '0;
                    cnt_q[l]   <= '0;
                    lb_q[l]    <= '0;
                end
            end

            if (advance) begin
                wcnt_q <= sel_delay;
            end else if (state_q == S_WAIT) begin
                wcnt_q <= wcnt_q - FW'(1);
            end

            if (cfg_wr) begin
                for (int l = 0; l < NUM_LEVELS; l++) begin
                    if (f_lvl == 4'(l)) begin
`ifdef REP_ADDR_GEN_REPX_EN
                        if (is_repx) begin
                            iter_q[l]  <= {f_iter,  iter_q[l][5:0]};
                            step_q[l]  <= {f_step,  step_q[l][5:0]};
                            delay_q[l] <= {f_delay, delay_q[l][5:0]};
                        end else begin
                            iter_q[l]  <= {6'd0, f_iter};
                            step_q[l]  <= {6'd0, f_step};
                            delay_q[l] <= {6'd0, f_delay};
                        end
`else
                        iter_q[l]  <= f_iter;
                        step_q[l]  <= f_step;
                        delay_q[l] <= f_delay;
`endif
                    end
                end
            end
        end
    end

    assign bus.instr_ready = (state_q == S_IDLE);
    assign bus.addr_valid  = (state_q == S_RUN);
    assign bus.addr        = lb_q[0];
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_RUN) && !found;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_rep_addr_gen.sv
// tb/tb_rep_addr_gen.sv - directed self-checking bench for rep_addr_gen
module tb_rep_addr_gen;
    localparam int ADDR_W     = 16;
    localparam int NUM_LEVELS = 4;
    localparam int SLOT_ID    = 0;
    localparam int PORT_ID    = 0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    rep_addr_gen_if #(.ADDR_W(ADDR_W)) bus ();

    rep_addr_gen #(
        .SLOT_ID   (SLOT_ID),
        .PORT_ID   (PORT_ID),
        .NUM_LEVELS(NUM_LEVELS),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [27:0] pl(input int slot, input int port, input int level,
                                       input int iter, input int step, input int delay);
        return {4'(slot), 2'(port), 4'(level), 6'(iter), 6'(step), 6'(delay)};
    endfunction

    task automatic send(input logic [2:0] op, input logic [27:0] p);
        @(negedge clk);
        bus.instr_valid   = 1'b1;
        bus.instr_opcode  = op;
        bus.instr_payload = p;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
    endtask

    task automatic chk_err(input string tag, input logic exp);
        @(negedge clk);
        chk(tag, bus.err, exp);
    endtask

    // exp holds one entry per cycle after activate; negative means idle cycle
    task automatic run_check(input string tag, input logic [15:0] base, input int exp[$]);
        @(negedge clk);
        bus.activate  = 1'b1;
        bus.base_addr = base;
        @(posedge clk);
        #1;
        bus.activate = 1'b0;
        for (int i = 0; i < exp.size(); i++) begin
            @(negedge clk);
            chk({tag, " busy"}, bus.busy, 1'b1);
            if (exp[i] < 0) begin
                chk({tag, " idle"}, bus.addr_valid, 1'b0);
            end else begin
                chk({tag, " valid"}, bus.addr_valid, 1'b1);
                chk({tag, " addr"}, bus.addr, exp[i]);
            end
            chk({tag, " done"}, bus.done, (i == exp.size() - 1));
        end
        @(negedge clk);
        chk({tag, " busy_end"}, bus.busy, 1'b0);
        chk({tag, " ready_end"}, bus.instr_ready, 1'b1);
        chk({tag, " valid_end"}, bus.addr_valid, 1'b0);
    endtask

    initial begin
        int q[$];
        rst_n             = 1'b0;
        bus.instr_valid   = 1'b0;
        bus.instr_opcode  = 3'd0;
        bus.instr_payload = '0;
        bus.activate      = 1'b0;
        bus.base_addr     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst ready", bus.instr_ready, 1'b1);
        chk("rst valid", bus.addr_valid, 1'b0);
        chk("rst addr", bus.addr, 16'h0);
        chk("rst busy", bus.busy, 1'b0);
        chk("rst done", bus.done, 1'b0);
        chk("rst err", bus.err, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: single level, consecutive addresses
        send(3'd0, pl(0, 0, 0, 3, 2, 0));
        chk_err("t1 err", 1'b0);
        q = {16'h10, 16'h12, 16'h14, 16'h16};
        run_check("t1", 16'h10, q);

        // 2: two levels with outer delay
        send(3'd0, pl(0, 0, 0, 1, 1, 0));
        send(3'd0, pl(0, 0, 1, 2, 8, 2));
        q = {0, 1, -1, -1, 8, 9, -1, -1, 16, 17};
        run_check("t2", 16'h0, q);

        // 3: step 6'h3F (negative only when the field is 6 bits wide)
        send(3'd0, pl(0, 0, 0, 2, 63, 0));
`ifdef REP_ADDR_GEN_REPX_EN
        q = {5, 68, 131};
`else
        q = {5, 4, 3};
`endif
        run_check("t3", 16'h5, q);

        // 4: foreign slot dropped silently, out-of-range level flagged
        send(3'd0, pl(SLOT_ID + 1, 0, 0, 3, 1, 0));
        chk_err("t4 foreign err", 1'b0);
        send(3'd0, pl(0, 0, NUM_LEVELS, 3, 1, 0));
        chk_err("t4 level err", 1'b1);
        @(negedge clk);
        chk("t4 err pulse", bus.err, 1'b0);
        q = {16'h33};
        run_check("t4", 16'h33, q);

        // 5: repx extends the iteration count
        send(3'd0, pl(0, 0, 0, 1, 1, 0));
        send(3'd1, pl(0, 0, 0, 1, 0, 0));
`ifdef REP_ADDR_GEN_REPX_EN
        chk_err("t5 repx err", 1'b0);
        q = {};
        for (int i = 0; i < 66; i++) q.push_back(i);
`else
        chk_err("t5 repx err", 1'b1);
        q = {0, 1};
`endif
        run_check("t5", 16'h0, q);

        // 6: reset in the middle of a run
        send(3'd0, pl(0, 0, 0, 1, 1, 0));
        send(3'd0, pl(0, 0, 1, 2, 8, 2));
        @(negedge clk);
        bus.activate  = 1'b1;
        bus.base_addr = 16'h0;
        @(posedge clk);
        #1;
        bus.activate = 1'b0;
        @(negedge clk);
        chk("t6 a0", bus.addr, 16'h0);
        @(negedge clk);
        chk("t6 a1", bus.addr, 16'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6 rst valid", bus.addr_valid, 1'b0);
        chk("t6 rst busy", bus.busy, 1'b0);
        chk("t6 rst done", bus.done, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q = {16'h7};
        run_check("t6", 16'h7, q);

        // 7: word coinciding with activate does not affect that run
        @(negedge clk);
        bus.instr_valid   = 1'b1;
        bus.instr_opcode  = 3'd0;
        bus.instr_payload = pl(0, 0, 0, 2, 1, 0);
        bus.activate      = 1'b1;
        bus.base_addr     = 16'h20;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        bus.activate    = 1'b0;
        @(negedge clk);
        chk("t7 valid", bus.addr_valid, 1'b1);
        chk("t7 addr", bus.addr, 16'h20);
        chk("t7 done", bus.done, 1'b1);
        @(negedge clk);
        chk("t7 busy_end", bus.busy, 1'b0);
        q = {16'h40};
        run_check("t7b", 16'h40, q);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
